imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Writer side of the instruction-memory interface.
- Receives a byte stream over a valid/ready handshake and writes the bytes into the byte-addressed instruction memory (9-bit address, big-endian words), replacing file preload.
- Holds the pipeline (cpu_hold) from reset until a complete, valid program image has been written.
- Sits between the host/testbench byte source and the instruction memory write port, alongside the fetch stage.

Parameters:
ADDR_WIDTH, 9, instruction memory byte-address width
MAX_BYTES, 512, largest accepted payload length in bytes
BASE_ADDR, 0, first byte address written

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
rx_data  input  8  incoming stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte this cycle
mem_addr  output  ADDR_WIDTH  instruction memory write byte address
mem_data  output  8  instruction memory write byte
mem_we  output  1  instruction memory write enable, one cycle per byte
cpu_hold  output  1  stall/hold for PC, nPC and IF/ID
busy  output  1  load in progress
done  output  1  image loaded successfully
error  output  1  load aborted
bytes_loaded  output  10  payload bytes written in the current/last load

Behaviour:
- Reset (async, active-high): state IDLE; rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, cpu_hold=1, busy=0, done=0, error=0, bytes_loaded=0, length register=0. Memory contents are untouched.
- Byte transfer: a byte transfers on a rising clk edge when rx_valid && rx_ready. rx_data must be held while rx_valid=1 && rx_ready=0.
- States and transitions:
  - IDLE: rx_ready=0. start -> LEN_HI.
  - LEN_HI: rx_ready=1. Accepted byte -> length[15:8]; go to LEN_LO.
  - LEN_LO: rx_ready=1. Accepted byte -> length[7:0].
    - length==0 -> DONE.
    - length>MAX_BYTES -> ERR.
    - otherwise -> LOAD.
  - LOAD: rx_ready=1.
    - Each accepted byte is registered to mem_data, with mem_addr=BASE_ADDR+bytes_loaded (mod 2^ADDR_WIDTH); mem_we=1 the following cycle; bytes_loaded increments in that same cycle.
    - On acceptance of byte number length -> DONE (or CHECK when the optional feature is compiled in).
  - DONE: done=1, cpu_hold=0, rx_ready=0. start -> LEN_HI; done and bytes_loaded clear and cpu_hold reasserts on the following cycle.
  - ERR: error=1, cpu_hold=1, rx_ready=0. start -> LEN_HI; error clears.
- Output rules:
  - busy=1 in LEN_HI, LEN_LO, LOAD and CHECK.
  - cpu_hold=1 in every state except DONE.
- Write latency: exactly 1 cycle from byte acceptance to mem_we. The final write's mem_we pulse coincides with the first DONE cycle.
- Back-to-back bytes (rx_valid held high) give one mem_we per cycle. There are no bubbles.
- start while busy=1 is ignored. start coinciding with a handshake in DONE or ERR: start wins, and no byte is consumed that cycle.
- Address wrap: BASE_ADDR+count wraps modulo 2^ADDR_WIDTH.
- Reset asserted mid-load: immediate return to reset values. Partially written memory is left as-is.
- bytes_loaded saturates at length; it never exceeds MAX_BYTES.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last payload byte, the loader enters CHECK (rx_ready=1) and accepts one checksum byte.
  - If the 8-bit sum mod 256 of all payload bytes plus the checksum byte equals 0x00 -> DONE; else -> ERR.
  - Checksum accumulator resets on start.
  - length==0 also requires a checksum byte (must be 0x00).
- Not defined:
  - No CHECK state. The last payload byte goes directly to DONE.
  - No trailer byte is consumed.

Test Plan:
- Reset, then start, stream 00 04 8C 22 00 08 with rx_valid constant -> mem_we pulses on 4 consecutive cycles at addresses 0,1,2,3 with data 8C,22,00,08. done=1 and cpu_hold=0 on the cycle of the 4th write. bytes_loaded=4.
- Stream 00 02 AA BB with rx_valid toggling 1,0,1,0 -> exactly 2 writes (addr 0=AA, addr 1=BB), and no write in cycles without a handshake.
- Length 02 01 (513) -> ERR; error=1, cpu_hold=1, no mem_we. Then start + 00 01 55 -> addr 0=55, done=1, error=0.
- Reset asserted after 2 of 4 payload bytes -> all outputs at reset values immediately. A subsequent start reloads from address BASE_ADDR.
- start pulsed while busy during LOAD -> ignored; load completes normally with the original length.
- With IMEM_LOADER_CHECKSUM_EN: 00 02 10 20 D0 -> DONE. The same stream with trailer D1 -> ERR. Both loads produce 2 writes first.

Source files
------------

// File: rtl/imem_program_loader.sv
// Streams a length-prefixed program image into the byte-addressed instruction memory
// and holds the CPU until a complete image is in place. Optional trailer check: IMEM_LOADER_CHECKSUM_EN.
module imem_program_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int MAX_BYTES  = 512,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [9:0]            bytes_loaded,
  output logic [2:0]            dbg_state
);

  // Handshake: a byte moves on a rising clk edge when rx_valid && rx_ready; the source
  // holds rx_data stable while rx_valid=1 and rx_ready=0. rx_ready is a registered state decode.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_LOAD   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_PAYLOAD = S_CHECK;
`else
  localparam state_t S_AFTER_PAYLOAD = S_DONE;
`endif

  state_t                r_state;
  state_t                w_next;
  logic                  r_rx_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_cpu_hold;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_data;
  logic [9:0]            r_bytes_loaded;
  logic [15:0]           r_length;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_start_ok;
  logic [15:0]           w_len_full;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
  logic [7:0]            w_sum_final;
`endif

  always_comb begin
    w_accept   = rx_valid && r_rx_ready;
    w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    w_len_full = {r_length[15:8], rx_data};
    w_last     = (({6'd0, r_bytes_loaded} + 16'd1) == r_length);
    w_wr_addr  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_bytes_loaded);
`ifdef IMEM_LOADER_CHECKSUM_EN
    w_sum_final = r_sum + rx_data;
`endif
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start_ok) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_full == 16'd0)                  w_next = S_AFTER_PAYLOAD;
          else if (w_len_full > 16'(MAX_BYTES))     w_next = S_ERR;
          else                                      w_next = S_LOAD;
        end
      end
      S_LOAD: if (w_accept && w_last) w_next = S_AFTER_PAYLOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: if (w_accept) w_next = (w_sum_final == 8'd0) ? S_DONE : S_ERR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rx_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= ADDR_WIDTH'(BASE_ADDR);
      r_mem_data     <= 8'd0;
      r_bytes_loaded <= 10'd0;
      r_length       <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum          <= 8'd0;
`endif
    end else begin
      r_state    <= w_next;
      // Status flags are decoded from the next state so they change with the state register.
      r_rx_ready <= (w_next == S_LEN_HI || w_next == S_LEN_LO || w_next == S_LOAD || w_next == S_CHECK);
      r_busy     <= (w_next == S_LEN_HI || w_next == S_LEN_LO || w_next == S_LOAD || w_next == S_CHECK);
      r_done     <= (w_next == S_DONE);
      r_error    <= (w_next == S_ERR);
      r_cpu_hold <= (w_next != S_DONE);
      r_mem_we   <= 1'b0;
      if (w_start_ok) begin
        r_bytes_loaded <= 10'd0;
        r_length       <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum          <= 8'd0;
`endif
      end
      if (w_accept) begin
        case (r_state)
          S_LEN_HI: r_length[15:8] <= rx_data;
          S_LEN_LO: r_length[7:0]  <= rx_data;
          S_LOAD: begin
            r_mem_we       <= 1'b1;
            r_mem_data     <= rx_data;
            r_mem_addr     <= w_wr_addr;
            r_bytes_loaded <= r_bytes_loaded + 10'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum          <= r_sum + rx_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready     = r_rx_ready;
  assign mem_addr     = r_mem_addr;
  assign mem_data     = r_mem_data;
  assign mem_we       = r_mem_we;
  assign cpu_hold     = r_cpu_hold;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign bytes_loaded = r_bytes_loaded;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: directed program images, per-cycle model compare, literal checks.
module tb_imem_program_loader;

  localparam int AW  = 9;
  localparam int MAXB = 512;
  localparam int BASE = 0;

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [9:0]    bytes_loaded;
  logic [2:0]    dbg_state;

  imem_program_loader #(.ADDR_WIDTH(AW), .MAX_BYTES(MAXB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .bytes_loaded(bytes_loaded), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: header count, payload count, running sum
  bit   m_busy, m_done, m_err, m_ck, m_we;
  int   m_hdr, m_len, m_cnt, m_sum, m_addr;
  logic [7:0] m_data;

  // observed write log (scoreboard for literal checks)
  logic [AW-1:0] la[$];
  logic [7:0]    ld[$];
  logic          lf[$];

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_ck = 0; m_we = 0;
    m_hdr = 0; m_len = 0; m_cnt = 0; m_sum = 0; m_addr = BASE; m_data = 8'h00;
  endtask

  task automatic payload_complete();
`ifdef IMEM_LOADER_CHECKSUM_EN
    m_ck = 1;
`else
    m_busy = 0;
    m_done = 1;
`endif
  endtask

  task automatic model_step(input logic st, input logic v, input logic [7:0] d);
    m_we = 0;
    if (!m_busy) begin
      if (st) begin
        m_busy = 1; m_done = 0; m_err = 0; m_ck = 0;
        m_hdr = 0; m_len = 0; m_cnt = 0; m_sum = 0;
      end
    end else if (v) begin
      if (m_hdr < 2) begin
        m_len = m_len * 256 + int'(d);
        m_hdr++;
        if (m_hdr == 2) begin
          if (m_len > MAXB) begin m_busy = 0; m_err = 1; end
          else if (m_len == 0) payload_complete();
        end
      end else if (!m_ck) begin
        m_we   = 1;
        m_addr = (BASE + m_cnt) % (1 << AW);
        m_data = d;
        m_cnt++;
        m_sum += int'(d);
        if (m_cnt == m_len) payload_complete();
      end else begin
        m_sum += int'(d);
        m_busy = 0;
        if (m_sum % 256 == 0) m_done = 1;
        else                  m_err  = 1;
      end
    end
  endtask

  // compare process: outputs checked every cycle at the falling edge
  initial begin
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      chk("rx_ready", 32'(rx_ready), 32'(m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      chk("bytes_loaded", 32'(bytes_loaded), 32'(m_cnt));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_data", 32'(mem_data), 32'(m_data));
      end
      if (mem_we) begin
        la.push_back(mem_addr);
        ld.push_back(mem_data);
        lf.push_back(done);
      end
      if (!reset) model_step(start, rx_valid, rx_data);
    end
  end

  // driver tasks
  logic [7:0] stim_q[$];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    start    = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int   guard;
    logic rdy;
    repeat (gap) begin
      rx_valid = 1'b0;
      cyc();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    do begin
      rdy = rx_ready;
      cyc();
      guard++;
    end while (!rdy && guard < 64);
    if (!rdy) chk("handshake_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic send_stream(input int gap, input bit add_ck);
    logic [7:0] s;
    s = 8'h00;
    foreach (stim_q[i]) begin
      send_byte(stim_q[i], (i == 0) ? 0 : gap);
      if (i >= 2) s = s + stim_q[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (add_ck) send_byte(8'h00 - s, gap);
`else
    if (add_ck) s = 8'h00;
`endif
    rx_valid = 1'b0;
  endtask

  task automatic clear_log();
    la.delete();
    ld.delete();
    lf.delete();
  endtask

  task automatic chk_wr(input string name, input int idx, input int addr, input int data);
    if (idx < la.size()) begin
      chk({name, "_addr"}, 32'(la[idx]), 32'(addr));
      chk({name, "_data"}, 32'(ld[idx]), 32'(data));
    end else begin
      chk({name, "_missing"}, 32'(la.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [7:0] p;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_mem_data", 32'(mem_data), 32'h00);
    chk("rst_busy_done_err_we", {28'd0, busy, done, error, mem_we}, 32'd0);
    reset = 1'b0;
    cyc();

    // 1: four-byte image, rx_valid held high
    clear_log();
    pulse_start();
    stim_q = '{8'h00, 8'h04, 8'h8C, 8'h22, 8'h00, 8'h08};
    send_stream(0, 1'b1);
    idle(3);
    chk("t1_nwr", 32'(la.size()), 32'd4);
    chk_wr("t1_w0", 0, 0, 8'h8C);
    chk_wr("t1_w1", 1, 1, 8'h22);
    chk_wr("t1_w2", 2, 2, 8'h00);
    chk_wr("t1_w3", 3, 3, 8'h08);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (lf.size() == 4) chk("t1_done_on_last_wr", 32'(lf[3]), 32'd1);
`endif
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t1_bytes_loaded", 32'(bytes_loaded), 32'd4);

    // 2: start coinciding with a presented byte in DONE, then toggling rx_valid
    clear_log();
    rx_valid = 1'b1; rx_data = 8'hFF;
    pulse_start();
    rx_valid = 1'b0;
    stim_q = '{8'h00, 8'h02, 8'hAA, 8'hBB};
    send_stream(1, 1'b1);
    idle(3);
    chk("t2_nwr", 32'(la.size()), 32'd2);
    chk_wr("t2_w0", 0, 0, 8'hAA);
    chk_wr("t2_w1", 1, 1, 8'hBB);
    chk("t2_bytes_loaded", 32'(bytes_loaded), 32'd2);

    // 3: oversize length 513 then recovery
    clear_log();
    pulse_start();
    stim_q = '{8'h02, 8'h01};
    send_stream(0, 1'b0);
    idle(3);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t3_nwr", 32'(la.size()), 32'd0);
    pulse_start();
    stim_q = '{8'h00, 8'h01, 8'h55};
    send_stream(0, 1'b1);
    idle(3);
    chk_wr("t3_w0", 0, 0, 8'h55);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_error_clr", 32'(error), 32'd0);

    // 4: reset after two of four payload bytes
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t4_rst_we", 32'(mem_we), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_hold", 32'(cpu_hold), 32'd1);
    chk("t4_rst_bytes", 32'(bytes_loaded), 32'd0);
    chk("t4_rst_addr", 32'(mem_addr), 32'(BASE));
    idle(2);
    reset = 1'b0;
    cyc();
    clear_log();
    pulse_start();
    stim_q = '{8'h00, 8'h01, 8'h77};
    send_stream(0, 1'b1);
    idle(3);
    chk_wr("t4_w0", 0, 0, 8'h77);

    // 5: start pulsed while loading is ignored
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    start = 1'b1;
    send_byte(8'hBB, 0);
    start = 1'b0;
    send_byte(8'hCC, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    p = 8'h00 - (8'hAA + 8'hBB + 8'hCC);
    send_byte(p, 0);
`endif
    idle(3);
    chk("t5_nwr", 32'(la.size()), 32'd3);
    chk_wr("t5_w2", 2, 2, 8'hCC);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_bytes_loaded", 32'(bytes_loaded), 32'd3);

    // 6: zero-length image
    clear_log();
    pulse_start();
    stim_q = '{8'h00, 8'h00};
    send_stream(0, 1'b1);
    idle(3);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_nwr", 32'(la.size()), 32'd0);

    // 7: maximum length 512
    clear_log();
    pulse_start();
    stim_q = '{8'h02, 8'h00};
    for (int i = 0; i < 512; i++) begin
      p = 8'(i) ^ 8'h5A;
      stim_q.push_back(p);
    end
    send_stream(0, 1'b1);
    idle(3);
    chk("t7_nwr", 32'(la.size()), 32'd512);
    chk_wr("t7_last", 511, 511, 8'hA5);
    chk("t7_bytes_loaded", 32'(bytes_loaded), 32'd512);
    chk("t7_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 8: checksum trailer good / bad
    clear_log();
    pulse_start();
    stim_q = '{8'h00, 8'h02, 8'h10, 8'h20, 8'hD0};
    send_stream(0, 1'b0);
    idle(3);
    chk("t8_nwr_good", 32'(la.size()), 32'd2);
    chk("t8_done", 32'(done), 32'd1);
    clear_log();
    pulse_start();
    stim_q = '{8'h00, 8'h02, 8'h10, 8'h20, 8'hD1};
    send_stream(0, 1'b0);
    idle(3);
    chk("t8_nwr_bad", 32'(la.size()), 32'd2);
    chk("t8_error", 32'(error), 32'd1);
    chk("t8_hold", 32'(cpu_hold), 32'd1);
`endif

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
